gated_d_reg_bank: RTL

Multi-channel, parametrised successor to the single-bit gated D storage element. Stores CHANNELS words of WIDTH bits in a shadow bank. A commit sequencer copies staged channels to the visible Q/Q_not outputs, one channel per clock. Used wherever several control words must be written piecemeal and then made visible in a controlled sequence.

---
 rtl/gated_d_pkg.sv | 8 +
 rtl/gated_d_reg_cell.sv | 20 ++
 rtl/gated_d_reg_bank.sv | 83 ++++++++
 3 files changed

// File: rtl/gated_d_pkg.sv
// gated_d_pkg: shared state type, channel-index width helper and reset value for the gated D register bank.
package gated_d_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic RESET_Q = '0;
  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gated_d_reg_cell.sv
// gated_d_reg_cell: one WIDTH-bit visible register with load enable, sync active-low reset and complementary outputs.
module gated_d_reg_cell
  import gated_d_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_not
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge Clk)
    if (!Reset) r_q <= {WIDTH{RESET_Q}};
    else if (i_load) r_q <= i_d;
  assign o_q     = r_q;
  assign o_q_not = ~r_q;
endmodule

// File: rtl/gated_d_reg_bank.sv
// gated_d_reg_bank: shadow bank of CHANNELS words made visible by a one-channel-per-clock commit scan.
// Optional GATED_D_BYPASS_EN adds a Bypass input for same-edge visible writes.
module gated_d_reg_bank
  import gated_d_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int CH_W    = ch_w(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Enable,
  input  logic                      Wr_valid,
  output logic                      Wr_ready,
  input  logic [CH_W-1:0]           Wr_ch,
  input  logic [WIDTH-1:0]          Wr_data,
`ifdef GATED_D_BYPASS_EN
  input  logic                      Bypass,
`endif
  input  logic                      Commit,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS*WIDTH-1:0] Q_not,
  output logic [CHANNELS-1:0]       Pending,
  output logic                      Busy,
  output logic                      Wr_err
);
  state_t            r_state;
  logic [CH_W-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_shadow [CHANNELS];
  logic [CHANNELS-1:0] r_pend;
  logic              r_err;
  logic              w_acc, w_in, w_byp, w_scan;
  assign Wr_ready = Enable && (r_state == IDLE);
  assign w_acc    = Wr_valid && Wr_ready;
  assign w_in     = 32'(Wr_ch) < CHANNELS;
  assign w_scan   = Enable && (r_state == SCAN);
`ifdef GATED_D_BYPASS_EN
  assign w_byp    = w_acc && w_in && Bypass;
`else
  assign w_byp    = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) r_shadow[i] <= '0;
    end else if (Enable) begin
      if (w_acc && w_in) begin
        r_shadow[Wr_ch] <= Wr_data;
        r_pend[Wr_ch]   <= !w_byp;
      end
      if (w_acc && !w_in) r_err <= 1'b1;
      if (r_state == IDLE) begin
        if (Commit) begin
          r_state <= SCAN;
          r_cnt   <= '0;
        end
      end else begin
        r_pend[r_cnt] <= 1'b0;
        r_cnt         <= r_cnt + 1'b1;
        if (r_cnt == CH_W'(CHANNELS - 1)) r_state <= IDLE;
      end
    end
  end
  // Scan loads and bypass loads never coincide: bypass writes only happen in IDLE.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_cell
    logic w_load;
    assign w_load = (w_scan && r_cnt == CH_W'(g) && r_pend[g]) || (w_byp && Wr_ch == CH_W'(g));
    gated_d_reg_cell #(.WIDTH(WIDTH)) u_cell (
      .Clk    (Clk),
      .Reset  (Reset),
      .i_load (w_load),
      .i_d    (w_byp ? Wr_data : r_shadow[g]),
      .o_q    (Q[g*WIDTH +: WIDTH]),
      .o_q_not(Q_not[g*WIDTH +: WIDTH])
    );
  end
  assign Pending = r_pend;
  assign Busy    = (r_state == SCAN);
  assign Wr_err  = r_err;
endmodule
